cursor_flash: RTL and testbench
===============================

# cursor_flash

Blink-timing generator for the VGA text console's cursor. It divides the pixel/system clock into alternating ON and OFF phases and drives a one-bit `flash` level. The character displayer uses `flash` to paint the cursor cell solid (1) or blank (0). The block is self-contained and has no dependence on the scan position.

## Interface
Parameters:
- `ON_CYCLES`, default 25_000_000: length of the ON phase in `clk` cycles (0.5 s at 50 MHz); legal range ≥ 1.
- `OFF_CYCLES`, default 25_000_000: length of the OFF phase in `clk` cycles; legal range ≥ 1.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  blink enable; 0 forces the cursor off.
- `kick`  input  1  activity pulse (keystroke or cursor move); see Configuration.
- `flash`  output  1  cursor visible level; registered.
- `tick`  output  1  one-cycle pulse on every `flash` transition caused by phase expiry; registered.

One clock; reset is asynchronous and active-low.

## Operation
- State: `flash` register (it is also the phase: 1 = ON, 0 = OFF) and a phase counter `cnt`.
  - `cnt` width is ceil(log2(max(ON_CYCLES, OFF_CYCLES))), minimum 1 bit.
- Reset (`rst_n` = 0): `flash` = 0, `cnt` = 0, `tick` = 0, applied immediately without waiting for a clock edge.
- `en` = 0: on each edge `flash` ← 0, `cnt` ← 0, `tick` ← 0.
- `en` = 1, no kick: `LIMIT` = `ON_CYCLES` when `flash` = 1, else `OFF_CYCLES`.
  - If `cnt` == LIMIT−1: `flash` ← ~`flash`, `cnt` ← 0, `tick` ← 1.
  - Otherwise: `cnt` ← `cnt` + 1, `tick` ← 0.
- Priority, highest first: reset, then `en` = 0, then `kick` (when compiled in), then phase expiry.
- Counter arithmetic is unsigned. `cnt` never exceeds LIMIT−1 and never wraps.
- With `ON_CYCLES` = `OFF_CYCLES` = 1, `flash` toggles every cycle and `tick` is held at 1.

## Timing
- `flash` and `tick` are registered outputs with no combinational path from the inputs.
- After reset release with `en` = 1, the first `flash` rise occurs on the `OFF_CYCLES`-th rising edge.
- Blink period is `ON_CYCLES` + `OFF_CYCLES` cycles.
  - `flash` stays high for exactly `ON_CYCLES` cycles and low for exactly `OFF_CYCLES` cycles.
- `tick` goes high in the same cycle as the new `flash` value and stays high for exactly 1 cycle.
- When `en` rises 0→1, the OFF phase restarts from `cnt` = 0, so the next rise comes `OFF_CYCLES` edges later.
- Reset asserted mid-phase: the outputs clear at once. After release, timing restarts as from power-up.

## Configuration
- Macro `CURSOR_KICK_EN`.
- Defined: `kick` = 1 with `en` = 1 sets `flash` ← 1, `cnt` ← 0, `tick` ← 0 on that edge. This restarts a full ON phase so the cursor is visible right after typing.
  - A kick in the expiry cycle overrides the toggle.
  - Repeated kicks hold `flash` high.
- Not defined: the `kick` port is present but ignored, and behaviour is pure free-running blink.

## Test plan
Use `ON_CYCLES` = 4, `OFF_CYCLES` = 3 throughout.
- Reset and free run: assert `rst_n` = 0, release, hold `en` = 1.
  - `flash` = 0 for edges 1–2, rises at edge 3, and stays high for 4 cycles, then low for 3.
  - `tick` pulses exactly at edges 3, 7, 10, 14.
- Asynchronous reset: drop `rst_n` mid ON phase, between edges.
  - `flash` and `tick` go to 0 immediately.
  - After release, the first rise is at edge 3 again.
- Enable gating: set `en` = 0 during ON for 5 cycles.
  - `flash` = 0 from the next edge.
  - After `en` = 1, `flash` rises on the 3rd edge.
- Kick (with `CURSOR_KICK_EN`): pulse `kick` 1 cycle during OFF with `cnt` = 1.
  - `flash` = 1 on that edge and stays high 4 cycles, with no `tick` at the kick.
  - Without the macro, the waveform is identical to free run.
- Kick at expiry and gating priority: `kick` = 1 in the cycle where `cnt` = 3 in ON.
  - `flash` stays 1 for 4 more cycles.
  - `kick` = 1 together with `en` = 0 gives `flash` = 0.
- Minimum phases: `ON_CYCLES` = `OFF_CYCLES` = 1 → `flash` toggles every edge and `tick` is held at 1.

Source files
------------

// File: rtl/cursor_flash.sv
// -----------------------------------------------------------------------------
// cursor_flash
// Blink-timing generator for the text-console cursor. Divides clk into
// alternating ON and OFF phases and drives a registered `flash` level that the
// character displayer uses to paint the cursor cell solid (1) or blank (0).
//
// Parameters:
//   ON_CYCLES   length of the ON phase in clk cycles (>= 1)
//   OFF_CYCLES  length of the OFF phase in clk cycles (>= 1)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   blink enable; 0 forces the cursor off and restarts OFF phase
//   kick   in   activity pulse; restarts a full ON phase when the
//               CURSOR_KICK_EN macro is defined, ignored otherwise
//   flash  out  cursor visible level (registered)
//   tick   out  one-cycle pulse on each phase-expiry transition (registered)
//
// Build option: define CURSOR_KICK_EN to enable the kick restart.
//
// state  | meaning
// PH_OFF | cursor blank, counting OFF_CYCLES
// PH_ON  | cursor solid, counting ON_CYCLES
// -----------------------------------------------------------------------------
module cursor_flash #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    output logic flash,
    output logic tick
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

    phase_t            phase, phase_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  last;
    logic              tick_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_OFF;
            cnt   <= '0;
            tick  <= 1'b0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        last      = (phase == PH_ON) ? ON_LAST : OFF_LAST;

        if (!en) begin
            phase_nxt = PH_OFF;
            cnt_nxt   = '0;
`ifdef CURSOR_KICK_EN
        end else if (kick) begin
            // Activity restarts a full ON phase; this also wins over expiry.
            phase_nxt = PH_ON;
            cnt_nxt   = '0;
`endif
        end else if (cnt == last) begin
            phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
            cnt_nxt   = '0;
            tick_nxt  = 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

`ifndef CURSOR_KICK_EN
    logic unused_kick;
    assign unused_kick = kick;
`endif

    // The phase register bit is the flash level itself.
    assign flash = (phase == PH_ON);

endmodule

// File: tb/tb_cursor_flash.sv
module tb_cursor_flash;

    logic clk;
    logic rst_n;
    logic en;
    logic kick;
    logic flash;
    logic tick;
    logic en_min;
    logic kick_min;
    logic flash_min;
    logic tick_min;

    int total;
    int bad;

    cursor_flash #(.ON_CYCLES(4), .OFF_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .kick  (kick),
        .flash (flash),
        .tick  (tick)
    );

    cursor_flash #(.ON_CYCLES(1), .OFF_CYCLES(1)) dut_min (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_min),
        .kick  (kick_min),
        .flash (flash_min),
        .tick  (tick_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic ef, input logic et);
        step();
        chk({tag, "_flash"}, flash, ef);
        chk({tag, "_tick"}, tick, et);
    endtask

    // expected waveforms after reset release with en=1, edges 1..14
    logic [13:0] fr_flash;
    logic [13:0] fr_tick;

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        kick     = 1'b0;
        en_min   = 1'b1;
        kick_min = 1'b0;
        // bit i = edge i+1
        fr_flash = 14'b01_1110_0011_1100;
        fr_tick  = 14'b10_0010_0100_0100;

        // reset state
        #22;
        chk("rst_flash", flash, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_min_flash", flash_min, 1'b0);
        chk("rst_min_tick", tick_min, 1'b0);

        // free run, released between edges
        #5 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("free_e%0d_flash", i + 1), flash, fr_flash[i]);
            chk($sformatf("free_e%0d_tick", i + 1), tick, fr_tick[i]);
            chk($sformatf("min_e%0d_flash", i + 1), flash_min, ((i % 2) == 0) ? 1'b1 : 1'b0);
            chk($sformatf("min_e%0d_tick", i + 1), tick_min, 1'b1);
        end

        // continue: OFF edges 15,16, rise at 17
        step_chk("free_e15", 1'b0, 1'b0);
        step_chk("free_e16", 1'b0, 1'b0);
        step_chk("free_e17", 1'b1, 1'b1);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flash", flash, 1'b0);
        chk("arst_tick", tick, 1'b0);
        chk("arst_min_tick", tick_min, 1'b0);
        step();
        #2 rst_n = 1'b1;
        step_chk("arst_e1", 1'b0, 1'b0);
        step_chk("arst_e2", 1'b0, 1'b0);
        step_chk("arst_e3", 1'b1, 1'b1);
        step_chk("arst_e4", 1'b1, 1'b0);

        // enable gating during ON
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_chk($sformatf("gate_off%0d", i), 1'b0, 1'b0);
        end
        en = 1'b1;
        step_chk("gate_e1", 1'b0, 1'b0);
        step_chk("gate_e2", 1'b0, 1'b0);
        step_chk("gate_e3", 1'b1, 1'b1);

        // run through ON into OFF, cnt=1 after e5
        step_chk("kk_e1", 1'b1, 1'b0);
        step_chk("kk_e2", 1'b1, 1'b0);
        step_chk("kk_e3", 1'b1, 1'b0);
        step_chk("kk_e4", 1'b0, 1'b1);
        step_chk("kk_e5", 1'b0, 1'b0);
        kick = 1'b1;
`ifdef CURSOR_KICK_EN
        step_chk("kk_e6", 1'b1, 1'b0);
        kick = 1'b0;
        step_chk("kk_e7", 1'b1, 1'b0);
        step_chk("kk_e8", 1'b1, 1'b0);
        step_chk("kk_e9", 1'b1, 1'b0);
        step_chk("kk_e10", 1'b0, 1'b1);
`else
        step_chk("kk_e6", 1'b0, 1'b0);
        kick = 1'b0;
        step_chk("kk_e7", 1'b1, 1'b1);
        step_chk("kk_e8", 1'b1, 1'b0);
        step_chk("kk_e9", 1'b1, 1'b0);
        step_chk("kk_e10", 1'b1, 1'b0);
`endif

        // restart cleanly, then kick in the ON expiry cycle
        en = 1'b0;
        step_chk("kx_clr", 1'b0, 1'b0);
        en = 1'b1;
        step_chk("kx_e1", 1'b0, 1'b0);
        step_chk("kx_e2", 1'b0, 1'b0);
        step_chk("kx_e3", 1'b1, 1'b1);
        step_chk("kx_e4", 1'b1, 1'b0);
        step_chk("kx_e5", 1'b1, 1'b0);
        step_chk("kx_e6", 1'b1, 1'b0);
        kick = 1'b1;
`ifdef CURSOR_KICK_EN
        step_chk("kx_e7", 1'b1, 1'b0);
        step_chk("kx_e8", 1'b1, 1'b0);
        kick = 1'b0;
        step_chk("kx_e9", 1'b1, 1'b0);
`else
        step_chk("kx_e7", 1'b0, 1'b1);
        step_chk("kx_e8", 1'b0, 1'b0);
        kick = 1'b0;
        step_chk("kx_e9", 1'b0, 1'b0);
`endif
        // kick together with en=0: gating wins
        kick = 1'b1;
        en   = 1'b0;
        step_chk("kx_gate1", 1'b0, 1'b0);
        step_chk("kx_gate2", 1'b0, 1'b0);
        kick = 1'b0;
        en   = 1'b1;
        step_chk("kx_rel1", 1'b0, 1'b0);
        step_chk("kx_rel2", 1'b0, 1'b0);
        step_chk("kx_rel3", 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
